// File: rtl/result_handler.sv
// Result handler: times the password search, captures the winning controller and
// candidate, and streams them out as a byte frame with valid/ready handshaking.
module result_handler #(
    parameter int WORD_BYTES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      success,
    input  logic [1:0]                successfulController,
    input  logic [8*WORD_BYTES-1:0]   candidate0,
    input  logic [8*WORD_BYTES-1:0]   candidate1,
    input  logic [8*WORD_BYTES-1:0]   candidate2,
    input  logic [8*WORD_BYTES-1:0]   candidate3,
    input  logic                      search_done,
    output logic                      halt,
    output logic                      found,
    output logic                      not_found,
    output logic [7:0]                out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic [31:0]               search_cycles
);

    // state  | meaning
    // IDLE   | waiting for start, generator halted
    // SEARCH | generator running, counting cycles
    // SEND   | streaming {index, candidate bytes}
    // DONE   | result held until the next start
    typedef enum logic [1:0] {IDLE, SEARCH, SEND, DONE} state_t;

    localparam int W = 8 * WORD_BYTES;
    localparam logic [4:0] LAST_BEAT = 5'(WORD_BYTES);

    state_t         state;
    logic [W-1:0]   cand_shift;
    logic [4:0]     beat;
    logic [W-1:0]   sel_cand;

    always_comb begin
        sel_cand = candidate0;
        case (successfulController)
            2'd0:    sel_cand = candidate0;
            2'd1:    sel_cand = candidate1;
            2'd2:    sel_cand = candidate2;
            default: sel_cand = candidate3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            halt          <= 1'b1;
            found         <= 1'b0;
            not_found     <= 1'b0;
            out_data      <= 8'h00;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            search_cycles <= 32'd0;
            cand_shift    <= '0;
            beat          <= 5'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= SEARCH;
                        halt          <= 1'b0;
                        found         <= 1'b0;
                        not_found     <= 1'b0;
                        search_cycles <= 32'd0;
                    end
                end
                SEARCH: begin
                    if (search_cycles != 32'hFFFF_FFFF)
                        search_cycles <= search_cycles + 32'd1;
                    // success wins over a simultaneous search_done
                    if (success) begin
                        state      <= SEND;
                        halt       <= 1'b1;
                        found      <= 1'b1;
                        out_valid  <= 1'b1;
                        out_last   <= 1'b0;
                        out_data   <= {6'b0, successfulController};
                        cand_shift <= sel_cand;
                        beat       <= 5'd0;
                    end else if (search_done) begin
                        state     <= DONE;
                        halt      <= 1'b1;
                        not_found <= 1'b1;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            out_data   <= cand_shift[W-1 -: 8];
                            cand_shift <= cand_shift << 8;
                            beat       <= beat + 5'd1;
                            out_last   <= (beat + 5'd1 == LAST_BEAT);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_handler.sv
// Randomized scoreboard bench for result_handler: expected frames are queued at
// stimulus time and a negedge monitor pops them on every handshake.
module tb_result_handler;

    localparam int WB = 4;
    localparam int W  = 8 * WB;

    logic          clk = 1'b0;
    logic          reset, start, success, search_done, out_ready;
    logic [1:0]    sc;
    logic [W-1:0]  cand [4];
    logic          halt, found, not_found, out_valid, out_last;
    logic [7:0]    out_data;
    logic [31:0]   search_cycles;

    logic [8:0]    exp_q [$];
    int            vectors = 0;
    int            miscompares = 0;
    int            ready_mode = 0;

    result_handler #(.WORD_BYTES(WB)) dut (
        .clk(clk), .reset(reset), .start(start), .success(success),
        .successfulController(sc),
        .candidate0(cand[0]), .candidate1(cand[1]), .candidate2(cand[2]), .candidate3(cand[3]),
        .search_done(search_done), .halt(halt), .found(found), .not_found(not_found),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .search_cycles(search_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: handshake values are stable at the falling edge.
    logic       prev_stall = 1'b0;
    logic [8:0] prev_beat  = 9'h0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {23'b0, out_last, out_data}, {23'b0, prev_beat});
            if (out_valid && exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_valid: got data %h last %b, no beat expected at %0t",
                         out_data, out_last, $time);
            end else if (out_valid && out_ready) begin
                chk("beat", {23'b0, out_last, out_data}, {23'b0, exp_q.pop_front()});
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out_last, out_data};
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 1'b0; success = 1'b0; search_done = 1'b0;
    endtask

    // Reference frame: index byte, then candidate bytes most significant first.
    task automatic push_frame(input logic [1:0] idx, input logic [W-1:0] c);
        exp_q.push_back({1'b0, 6'b0, idx});
        for (int b = WB - 1; b >= 0; b--)
            exp_q.push_back({(b == 0), 8'((c >> (8 * b)) & 'hFF)});
    endtask

    task automatic start_search();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_halt", halt, 0);
        chk("start_found", found, 0);
        chk("start_not_found", not_found, 0);
        chk("start_cycles", search_cycles, 0);
    endtask

    task automatic search_idle(input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) cand[j] = W'($urandom);
            sc    = 2'($urandom);
            start = ($urandom_range(0, 3) == 0);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic drain_frame();
        for (int i = 0; i < 300 && (out_valid || exp_q.size() != 0); i++) begin
            if (out_valid) begin
                success     = 1'($urandom_range(0, 1));
                search_done = 1'($urandom_range(0, 1));
                start       = 1'($urandom_range(0, 1));
                sc          = 2'($urandom);
                for (int j = 0; j < 4; j++) cand[j] = W'($urandom);
            end else begin
                clear_inputs();
            end
            tick();
        end
        clear_inputs();
        chk("frame_drained", exp_q.size(), 0);
        chk("done_valid", out_valid, 0);
    endtask

    task automatic run_match(input int k, input logic [1:0] idx, input logic [W-1:0] c,
                             input bit with_done);
        start_search();
        search_idle(k - 1);
        for (int j = 0; j < 4; j++) cand[j] = W'($urandom);
        cand[idx]   = c;
        sc          = idx;
        success     = 1'b1;
        search_done = with_done;
        push_frame(idx, c);
        tick();
        clear_inputs();
        chk("match_halt", halt, 1);
        chk("match_found", found, 1);
        chk("match_not_found", not_found, 0);
        chk("match_cycles", search_cycles, k);
        chk("match_valid", out_valid, 1);
        drain_frame();
        chk("done_found", found, 1);
        chk("done_halt", halt, 1);
        chk("done_cycles", search_cycles, k);
    endtask

    task automatic run_miss(input int k);
        start_search();
        search_idle(k - 1);
        search_done = 1'b1;
        tick();
        clear_inputs();
        chk("miss_not_found", not_found, 1);
        chk("miss_found", found, 0);
        chk("miss_halt", halt, 1);
        chk("miss_cycles", search_cycles, k);
        for (int i = 0; i < 4; i++) begin
            success = 1'($urandom_range(0, 1));
            tick();
        end
        success = 1'b0;
        chk("miss_hold_not_found", not_found, 1);
        chk("miss_hold_cycles", search_cycles, k);
    endtask

    task automatic reset_mid_frame();
        logic [W-1:0] c;
        c = W'($urandom);
        ready_mode = 0;
        start_search();
        search_idle(3);
        cand[3] = c;
        sc      = 2'd3;
        success = 1'b1;
        push_frame(2'd3, c);
        tick();
        clear_inputs();
        for (int i = 0; i < 50 && exp_q.size() > WB + 1 - 3; i++) tick();
        chk("partial_beats", exp_q.size(), WB + 1 - 3);
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_halt", halt, 1);
        chk("rst_found", found, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_cycles", search_cycles, 0);
        for (int i = 0; i < 5; i++) begin
            success = 1'b1;
            sc      = 2'($urandom);
            tick();
            chk("idle_no_frame", out_valid, 0);
        end
        success = 1'b0;
        chk("idle_halt", halt, 1);
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        sc = 2'd0;
        for (int j = 0; j < 4; j++) cand[j] = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_halt", halt, 1);
        chk("reset_found", found, 0);
        chk("reset_not_found", not_found, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_last", out_last, 0);
        chk("reset_data", out_data, 0);
        chk("reset_cycles", search_cycles, 0);

        ready_mode = 0;
        run_match(10, 2'b10, 32'h61626364, 1'b0);
        ready_mode = 1;
        run_match(10, 2'b10, 32'h61626364, 1'b0);
        run_miss(5);
        ready_mode = 2;
        run_match(7, 2'b01, W'($urandom), 1'b1);
        reset_mid_frame();
        ready_mode = 0;
        run_match(4, 2'b00, W'($urandom), 1'b0);

        for (int n = 0; n < 10; n++) begin
            ready_mode = 2;
            if ($urandom_range(0, 3) == 0)
                run_miss($urandom_range(1, 20));
            else
                run_match($urandom_range(1, 20), 2'($urandom), W'($urandom),
                          1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/result_handler.md
RESULT_HANDLER -- requirements
Module: result_handler

Interface
REQ-001 Parameter WORD_BYTES, default 4: candidate password length in bytes, 1..16.
REQ-002 clk  input  1  module clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  single-cycle pulse; begins a new search.
REQ-005 success  input  1  registered success flag from the success detector.
REQ-006 successfulController  input  2  winning controller index, valid when success=1.
REQ-007 candidate0..candidate3  input  8*WORD_BYTES each  candidate under test in each MD5 controller, byte WORD_BYTES-1 in MSBs.
REQ-008 search_done  input  1  candidate generator has exhausted the keyspace.
REQ-009 halt  output  1  freezes generator and controllers when 1.
REQ-010 found  output  1  match captured.
REQ-011 not_found  output  1  keyspace exhausted without match.
REQ-012 out_data  output  8  result byte stream.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_ready  input  1  downstream accepts the byte.
REQ-015 out_last  output  1  marks final byte of the result frame.
REQ-016 search_cycles  output  32  clock cycles spent in SEARCH.

Function
REQ-017 FSM states SHALL be IDLE, SEARCH, SEND, DONE; all outputs registered.
REQ-018 IDLE: halt=1; start -> SEARCH next cycle with halt=0, found=0, not_found=0, search_cycles=0; success and search_done ignored.
REQ-019 SEARCH: search_cycles increments by 1 per cycle, saturating at 32'hFFFFFFFF.
REQ-020 SEARCH with success=1 in cycle N: latch successfulController and the selected candidateX bus; at N+1 halt=1, found=1, state SEND, out_valid=1.
REQ-021 SEARCH with success=0 and search_done=1: next cycle halt=1, not_found=1, state DONE, no frame emitted.
REQ-022 Simultaneous success and search_done SHALL be treated as success.
REQ-023 start in SEARCH SHALL be ignored.
REQ-024 SEND frame: WORD_BYTES+1 beats; beat 0 = {6'b0, latched index}; beats 1..WORD_BYTES = latched candidate bytes, MSB byte first.
REQ-025 A beat transfers when out_valid=1 and out_ready=1 on the same edge; next beat presented the following cycle.
REQ-026 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-027 out_last=1 only on beat WORD_BYTES; its transfer -> DONE with out_valid=0 next cycle.
REQ-028 SEND and DONE SHALL ignore success, successfulController, candidate and search_done changes.
REQ-029 DONE: halt, found, not_found, search_cycles hold; start -> SEARCH as in REQ-018.
REQ-030 start during SEND SHALL be ignored; frame completes first.

Reset
REQ-031 reset=1 SHALL force, next edge: state IDLE, halt=1, found=0, not_found=0, out_valid=0, out_last=0, out_data=8'h00, search_cycles=0, latched index/candidate=0.
REQ-032 reset SHALL take priority over all inputs in every state, including mid-frame; a partial frame is abandoned, not resumed.

Verification (WORD_BYTES=4)
REQ-033 reset, start, 10 cycles, success=1, index=2'b10, candidate2=32'h61626364, out_ready=1 -> halt=1, found=1 next cycle; beats 02,61,62,63,64, out_last on 64; search_cycles=10.
REQ-034 Same as REQ-033 with out_ready toggled 0/1 each cycle -> identical byte sequence, data stable on stalled cycles, no beat dropped or duplicated.
REQ-035 start then search_done=1 after 5 cycles -> not_found=1, halt=1, found=0, out_valid never 1, search_cycles=5.
REQ-036 success=1, index=2'b01 and search_done=1 same cycle -> found=1, not_found=0, beat 0 = 8'h01.
REQ-037 reset asserted after beat 2 -> next cycle out_valid=0, halt=1, found=0, state IDLE; success before start produces no frame.
REQ-038 From DONE, start -> halt=0, flags cleared, search_cycles restarts from 0; second match emits new frame correctly.
